// File: rtl/layer_cfg_pkg.sv
// Shared constants for the blend-layer configuration controller:
// register map, FSM encoding and default active-screen size.
package layer_cfg_pkg;

  localparam logic [2:0] ADDR_TOP   = 3'd0;
  localparam logic [2:0] ADDR_LEFT  = 3'd1;
  localparam logic [2:0] ADDR_WIDTH = 3'd2;
  localparam logic [2:0] ADDR_HGT   = 3'd3;
  localparam logic [2:0] ADDR_ALPHA = 3'd4;
  localparam logic [2:0] ADDR_STEP  = 3'd5;
  localparam logic [2:0] ADDR_EN    = 3'd6;
  localparam logic [2:0] ADDR_RSVD  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_FADE  = 2'd2;

  localparam int unsigned H_ACTIVE_DEF = 1920;
  localparam int unsigned V_ACTIVE_DEF = 1080;

endpackage

// File: rtl/layer_win_clip.sv
// One-axis window clip: the extent is trimmed so the window never runs
// past the active screen; a window starting off-screen collapses to zero.
module layer_win_clip (
  input  logic [11:0] i_pos,
  input  logic [11:0] i_size,
  input  logic [11:0] i_limit,
  output logic [11:0] o_size
);

  logic [11:0] w_room;

  assign w_room = i_limit - i_pos;

  always_comb begin
    o_size = '0;
    if (i_pos < i_limit)
      o_size = (i_size < w_room) ? i_size : w_room;
  end

endmodule

// File: rtl/layer_cfg_ctrl.sv
// Frame-synchronous shadow/active configuration for one blend layer, with
// atomic commit on the vsync rising edge and a per-frame alpha fade engine.
module layer_cfg_ctrl
  import layer_cfg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vs,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        commit_req,
  output logic        busy,
  output logic        commit_done,
  output logic        layer_en,
  output logic [11:0] top,
  output logic [11:0] left,
  output logic [11:0] width,
  output logic [11:0] height,
  output logic [7:0]  o_alpha
);

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

  logic        r_vs_d, r_pending, r_commit_done, r_layer_en, r_sh_en;
  logic [1:0]  r_state;
  logic [11:0] r_sh_top, r_sh_left, r_sh_width, r_sh_height;
  logic [7:0]  r_sh_alpha, r_sh_step, r_fade_tgt, r_fade_step, r_alpha;
  logic [11:0] r_top, r_left, r_width, r_height;
  logic        w_vs_edge;
  logic [11:0] w_clip_w, w_clip_h;
  logic [7:0]  w_alpha_next;
  logic        w_unused_wr_data;

  // Move cur toward tgt by step, landing exactly on tgt instead of overshooting.
  function automatic logic [7:0] fade_next(input logic [7:0] cur,
                                           input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic [8:0] sum;
    logic [8:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (cur < tgt)
      fade_next = (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
    else
      fade_next = (diff[8] || (diff[7:0] <= tgt)) ? tgt : diff[7:0];
  endfunction

  assign w_vs_edge        = i_vs & ~r_vs_d;
  assign w_alpha_next     = fade_next(r_alpha, r_fade_tgt, r_fade_step);
  assign w_unused_wr_data = ^wr_data[15:12];

  layer_win_clip u_clip_h (
    .i_pos   (r_sh_left),
    .i_size  (r_sh_width),
    .i_limit (H_LIM),
    .o_size  (w_clip_w)
  );

  layer_win_clip u_clip_v (
    .i_pos   (r_sh_top),
    .i_size  (r_sh_height),
    .i_limit (V_LIM),
    .o_size  (w_clip_h)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_top    <= '0;
      r_sh_left   <= '0;
      r_sh_width  <= '0;
      r_sh_height <= '0;
      r_sh_alpha  <= '0;
      r_sh_step   <= '0;
      r_sh_en     <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_TOP:   r_sh_top    <= wr_data[11:0];
        ADDR_LEFT:  r_sh_left   <= wr_data[11:0];
        ADDR_WIDTH: r_sh_width  <= wr_data[11:0];
        ADDR_HGT:   r_sh_height <= wr_data[11:0];
        ADDR_ALPHA: r_sh_alpha  <= wr_data[7:0];
        ADDR_STEP:  r_sh_step   <= wr_data[7:0];
        ADDR_EN:    r_sh_en     <= wr_data[0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d        <= 1'b0;
      r_pending     <= 1'b0;
      r_state       <= ST_IDLE;
      r_commit_done <= 1'b0;
      r_layer_en    <= 1'b0;
      r_top         <= '0;
      r_left        <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_alpha       <= '0;
      r_fade_tgt    <= '0;
      r_fade_step   <= '0;
    end else begin
      r_vs_d        <= i_vs;
      r_commit_done <= 1'b0;
      // A request arriving during APPLY belongs to the next frame, so it wins over the clear.
      if (commit_req)
        r_pending <= 1'b1;
      else if (r_state == ST_APPLY)
        r_pending <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_vs_edge && r_pending)
            r_state <= ST_APPLY;
        end
        ST_APPLY: begin
          r_top         <= r_sh_top;
          r_left        <= r_sh_left;
          r_width       <= r_sh_en ? w_clip_w : 12'd0;
          r_height      <= r_sh_en ? w_clip_h : 12'd0;
          r_layer_en    <= r_sh_en;
          r_commit_done <= 1'b1;
          r_fade_tgt    <= r_sh_alpha;
          r_fade_step   <= r_sh_step;
          if (r_sh_step == 8'd0) begin
            r_alpha <= r_sh_alpha;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FADE;
          end
        end
        ST_FADE: begin
          if (w_vs_edge) begin
            if (r_pending) begin
              r_state <= ST_APPLY;
            end else begin
              r_alpha <= w_alpha_next;
              if (w_alpha_next == r_fade_tgt)
                r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_pending | (r_state != ST_IDLE);
  assign commit_done = r_commit_done;
  assign layer_en    = r_layer_en;
  assign top         = r_top;
  assign left        = r_left;
  assign width       = r_width;
  assign height      = r_height;
  assign o_alpha     = r_alpha;

endmodule

// File: tb/tb_layer_cfg_ctrl.sv
// Directed bench for layer_cfg_ctrl: commit timing, clipping, enable gating,
// alpha fades, coincident/absorbed commits and reset during a fade.
module tb_layer_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vs = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        busy, commit_done, layer_en;
  logic [11:0] top, left, width, height;
  logic [7:0]  o_alpha;

  int n_cmp = 0;
  int n_err = 0;

  layer_cfg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_vs        (i_vs),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .busy        (busy),
    .commit_done (commit_done),
    .layer_en    (layer_en),
    .top         (top),
    .left        (left),
    .width       (width),
    .height      (height),
    .o_alpha     (o_alpha)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  // One vsync pulse; returns two cycles after the edge cycle (commit results visible).
  task automatic frame();
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({layer_en, top, left, width, height, o_alpha, busy, commit_done} !== 59'd0) begin
      n_err++;
      $display("FAIL reset_outputs got en=%0b t=%0d l=%0d w=%0d h=%0d a=%0d busy=%0b cd=%0b want all 0",
               layer_en, top, left, width, height, o_alpha, busy, commit_done);
    end
  endtask

  task automatic test_basic_commit();
    wr(3'd0, 16'd100); wr(3'd1, 16'd200); wr(3'd2, 16'd640); wr(3'd3, 16'd480);
    wr(3'd4, 16'd128); wr(3'd5, 16'd0);   wr(3'd6, 16'd1);   wr(3'd7, 16'hFFFF);
    commit();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_req got %0b want 1", busy); end
    commit();
    n_cmp++;
    if ({top, width, o_alpha} !== 32'd0) begin
      n_err++; $display("FAIL shadow_only got t=%0d w=%0d a=%0d want 0", top, width, o_alpha);
    end
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    n_cmp++;
    if ({top, commit_done} !== 13'd0) begin
      n_err++; $display("FAIL apply_cycle_early got t=%0d cd=%0b want 0/0", top, commit_done);
    end
    tick();
    n_cmp++;
    if ({layer_en, top, left, width, height, o_alpha, commit_done} !== {1'b1, 12'd100, 12'd200, 12'd640, 12'd480, 8'd128, 1'b1}) begin
      n_err++;
      $display("FAIL basic_apply got en=%0b t=%0d l=%0d w=%0d h=%0d a=%0d cd=%0b want 1/100/200/640/480/128/1",
               layer_en, top, left, width, height, o_alpha, commit_done);
    end
    tick();
    n_cmp++;
    if ({commit_done, busy} !== 2'b00) begin
      n_err++; $display("FAIL basic_after got cd=%0b busy=%0b want 0/0", commit_done, busy);
    end
    i_vs = 1'b1; tick(); i_vs = 1'b0; tick(); tick();
    n_cmp++;
    if ({commit_done, busy} !== 2'b00) begin
      n_err++; $display("FAIL absorbed_second_req got cd=%0b busy=%0b want 0/0", commit_done, busy);
    end
  endtask

  task automatic test_clip();
    wr(3'd1, 16'd1800); wr(3'd2, 16'd300); wr(3'd0, 16'd1000); wr(3'd3, 16'd200);
    commit(); frame();
    n_cmp++;
    if ({top, left, width, height} !== {12'd1000, 12'd1800, 12'd120, 12'd80}) begin
      n_err++; $display("FAIL clip_edge got t=%0d l=%0d w=%0d h=%0d want 1000/1800/120/80", top, left, width, height);
    end
    wr(3'd1, 16'd2000);
    commit(); frame();
    n_cmp++;
    if ({left, width, height} !== {12'd2000, 12'd0, 12'd80}) begin
      n_err++; $display("FAIL clip_offscreen got l=%0d w=%0d h=%0d want 2000/0/80", left, width, height);
    end
    wr(3'd6, 16'd0);
    commit(); frame();
    n_cmp++;
    if ({layer_en, top, left, width, height, o_alpha} !== {1'b0, 12'd1000, 12'd2000, 12'd0, 12'd0, 8'd128}) begin
      n_err++;
      $display("FAIL disable got en=%0b t=%0d l=%0d w=%0d h=%0d a=%0d want 0/1000/2000/0/0/128",
               layer_en, top, left, width, height, o_alpha);
    end
  endtask

  task automatic test_fade_in();
    logic [7:0] exp_a [4] = '{8'd64, 8'd128, 8'd192, 8'd255};
    wr(3'd6, 16'd1); wr(3'd4, 16'd0); wr(3'd5, 16'd0);
    commit(); frame();
    n_cmp++;
    if ({layer_en, o_alpha} !== {1'b1, 8'd0}) begin
      n_err++; $display("FAIL fade_start got en=%0b a=%0d want 1/0", layer_en, o_alpha);
    end
    wr(3'd4, 16'd255); wr(3'd5, 16'd64);
    commit(); frame();
    n_cmp++;
    if ({o_alpha, busy} !== {8'd0, 1'b1}) begin
      n_err++; $display("FAIL fade_apply got a=%0d busy=%0b want 0/1", o_alpha, busy);
    end
    for (int i = 0; i < 4; i++) begin
      i_vs = 1'b1;
      tick();
      i_vs = 1'b0;
      n_cmp++;
      if (o_alpha !== exp_a[i]) begin
        n_err++; $display("FAIL fade_in_step%0d got %0d want %0d", i, o_alpha, exp_a[i]);
      end
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL fade_in_busy got %0b want 0", busy); end
    frame();
    n_cmp++;
    if (o_alpha !== 8'd255) begin n_err++; $display("FAIL fade_in_hold got %0d want 255", o_alpha); end
  endtask

  task automatic test_coincident_commit();
    wr(3'd0, 16'd5);
    commit_req = 1'b1; i_vs = 1'b1;
    tick();
    commit_req = 1'b0; i_vs = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({top, busy} !== {12'd1000, 1'b1}) begin
      n_err++; $display("FAIL coincident_held got t=%0d busy=%0b want 1000/1", top, busy);
    end
    frame();
    n_cmp++;
    if ({top, height, commit_done} !== {12'd5, 12'd200, 1'b1}) begin
      n_err++; $display("FAIL coincident_next got t=%0d h=%0d cd=%0b want 5/200/1", top, height, commit_done);
    end
  endtask

  task automatic test_back_to_back();
    wr(3'd4, 16'd0); wr(3'd5, 16'd0);
    commit(); frame();
    wr(3'd4, 16'd255); wr(3'd5, 16'd64);
    commit(); frame();
    frame(); frame();
    n_cmp++;
    if ({o_alpha, busy} !== {8'd128, 1'b1}) begin
      n_err++; $display("FAIL midfade_setup got a=%0d busy=%0b want 128/1", o_alpha, busy);
    end
    wr(3'd4, 16'd0); wr(3'd5, 16'd100);
    commit();
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    n_cmp++;
    if ({o_alpha, commit_done} !== {8'd128, 1'b0}) begin
      n_err++; $display("FAIL midfade_no_step got a=%0d cd=%0b want 128/0", o_alpha, commit_done);
    end
    wr(3'd0, 16'd777);
    n_cmp++;
    if ({top, o_alpha, commit_done} !== {12'd5, 8'd128, 1'b1}) begin
      n_err++; $display("FAIL apply_prewrite got t=%0d a=%0d cd=%0b want 5/128/1", top, o_alpha, commit_done);
    end
    frame();
    n_cmp++;
    if (o_alpha !== 8'd28) begin n_err++; $display("FAIL fade_out_step0 got %0d want 28", o_alpha); end
    frame();
    n_cmp++;
    if ({o_alpha, busy} !== {8'd0, 1'b0}) begin
      n_err++; $display("FAIL fade_out_end got a=%0d busy=%0b want 0/0", o_alpha, busy);
    end
  endtask

  task automatic test_reset_midfade();
    wr(3'd4, 16'd255); wr(3'd5, 16'd10);
    commit(); frame(); frame();
    n_cmp++;
    if (o_alpha !== 8'd10) begin n_err++; $display("FAIL rst_setup got %0d want 10", o_alpha); end
    commit();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({layer_en, top, left, width, height, o_alpha, busy, commit_done} !== 59'd0) begin
      n_err++;
      $display("FAIL rst_midfade got en=%0b t=%0d l=%0d w=%0d h=%0d a=%0d busy=%0b want all 0",
               layer_en, top, left, width, height, o_alpha, busy);
    end
    for (int i = 0; i < 2; i++) begin
      frame();
      n_cmp++;
      if ({layer_en, top, width, o_alpha, busy, commit_done} !== 35'd0) begin
        n_err++;
        $display("FAIL rst_quiet%0d got en=%0b t=%0d w=%0d a=%0d busy=%0b cd=%0b want all 0",
                 i, layer_en, top, width, o_alpha, busy, commit_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_clip();
    test_fade_in();
    test_coincident_commit();
    test_back_to_back();
    test_reset_midfade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_cfg_ctrl.md
# layer_cfg_ctrl

Frame-synchronous configuration controller for one blend layer. The host writes window geometry, alpha target and fade rate into shadow registers. The block commits them atomically on the next frame-start edge, clipped to the active screen, and drives the layer's top/left/width/height/alpha inputs. It also runs a per-frame alpha fade engine, so the host can fade a layer in or out without per-frame intervention.

## Interface
- H_ACTIVE, 1920, active pixels per line (clip limit)
- V_ACTIVE, 1080, active lines per frame (clip limit)
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- i_vs  in  1  video vertical sync, active-high; rising edge = frame boundary
- wr_en  in  1  host register write strobe
- wr_addr  in  3  register select
- wr_data  in  16  write data
- commit_req  in  1  one-cycle pulse: apply shadow set at next frame boundary
- busy  out  1  commit pending or fade in progress
- commit_done  out  1  one-cycle pulse when shadow set applied
- layer_en  out  1  active layer enable
- top, left, width, height  out  12 each  active clipped window
- o_alpha  out  8  active alpha to blender

## Operation
- Register map, shadow side (geometry uses wr_data[11:0], others use the LSBs):
  - 0 top
  - 1 left
  - 2 width
  - 3 height
  - 4 alpha_target[7:0]
  - 5 fade_step[7:0], 0 = immediate
  - 6 enable[0]
  - 7 reserved, write ignored
- Writes update shadow only. Active outputs change only at a frame boundary.
- Frame edge: vs_d <= i_vs; vs_edge = i_vs & ~vs_d.
- commit_req sets pending. A second commit_req while pending is absorbed and leaves no side effects.
- States:
  - IDLE: vs_edge & pending -> APPLY.
  - APPLY, one cycle: copy clipped geometry and enable to active, clear pending, pulse commit_done. If fade_step==0: o_alpha <= alpha_target, -> IDLE. Otherwise latch target/step and go -> FADE. o_alpha is unchanged in this cycle.
  - FADE: on each vs_edge, o_alpha moves toward target by step, saturating exactly at target. When o_alpha reaches target -> IDLE.
  - FADE: if vs_edge & pending, go -> APPLY instead of stepping. The new fade starts from the current o_alpha.
- Clip, per axis: if left >= H_ACTIVE then width_out = 0; else width_out = min(width, H_ACTIVE - left). top/height are clipped the same way against V_ACTIVE. top/left pass through unmodified.
- enable = 0 forces width/height outputs to 0, so no front-layer reads occur. layer_en = 0 in this case. Alpha is still processed normally.
- Arithmetic is unsigned. The fade uses 9-bit intermediates, with no wrap below 0 or above 255.

## Timing
- Reset: all outputs 0, shadow regs 0, pending 0, state IDLE.
- rst mid-fade or mid-pending: state returns to IDLE next cycle and all outputs are 0. The pending commit is discarded.
- vs_edge at cycle N (pending): APPLY in N+1. Active outputs and commit_done are valid at N+2.
- A fade step on vs_edge at cycle N: o_alpha is updated at N+1.
- commit_req in the same cycle as vs_edge: not applied at this edge. It is applied at the following frame edge.
- wr_en in the APPLY cycle: APPLY uses the pre-write shadow value. The write lands in shadow only.
- Writes between commit_req and vs_edge: included in the commit.
- busy = pending | (state != IDLE). It goes high the cycle after commit_req and low the cycle after the final fade step or APPLY.

## Structure
- Package layer_cfg_pkg holds:
  - register address constants
  - state encoding (IDLE/APPLY/FADE)
  - default H_ACTIVE/V_ACTIVE
- Sub-module layer_win_clip: combinational one-axis clip (pos, size, limit -> size_out). It is instanced twice.

## Test plan
- Write top=100, left=200, width=640, height=480, alpha=128, step=0, enable=1; commit; vs edge at N -> outputs at N+2 equal 100/200/640/480, o_alpha=128, commit_done single pulse, busy low after.
- left=1800, width=300, top=1000, height=200 -> width=120, height=80. left=2000 -> width=0.
- Alpha 0 -> target 255, step=64 -> o_alpha 64, 128, 192, 255 on four successive frame edges. busy drops after 255. No further change.
- commit_req coincident with vs edge -> no update that frame; update at next edge.
- Mid-fade at o_alpha=128, new commit target 0, step=100 -> next edge APPLY; subsequent edges give 28, then 0.
- rst asserted during FADE with pending set -> next cycle all outputs 0, busy 0. Subsequent vs edges cause no change until a new commit.
